mdu_issue_scheduler: RTL and testbench

- Shares one non-abortable multi-cycle multiply/divide unit (MDU) between the issue lanes of the EX stage.
- Serialises MDU requests from a dual-issued bundle in program order (lane 0 first).
- Holds per-lane results until the bundle leaves EX.
- Raises a stall request to the pipeline controller while any requesting lane is unfinished.
- Tracks flushes so that stale MDU results are drained and discarded, never written back.

---
 rtl/mdu_issue_scheduler.sv | 121 ++++++++++++
 tb/tb_mdu_issue_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_scheduler.sv
// Serialises the MDU requests of one EX bundle onto a single shared multiply/divide unit,
// holds per-lane results until the bundle retires, and drains ops orphaned by a flush.
module mdu_issue_scheduler #(
    parameter int ISSUE_NUM = 2,
    parameter int OP_W      = 4,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          stall_ex,
    input  logic [ISSUE_NUM-1:0]          req,
    input  logic [ISSUE_NUM*OP_W-1:0]     op,
    input  logic [ISSUE_NUM*DATA_W-1:0]   src_a,
    input  logic [ISSUE_NUM*DATA_W-1:0]   src_b,
    output logic                          mdu_start,
    output logic [OP_W-1:0]               mdu_op,
    output logic [DATA_W-1:0]             mdu_a,
    output logic [DATA_W-1:0]             mdu_b,
    input  logic                          mdu_done,
    input  logic [2*DATA_W-1:0]           mdu_result,
    output logic [ISSUE_NUM*2*DATA_W-1:0] result,
    output logic [ISSUE_NUM-1:0]          result_valid,
    output logic                          stall_req
);
    localparam int LANE_W = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1;
    localparam int RES_W  = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [ISSUE_NUM-1:0]       done_q, done_d;
    logic [ISSUE_NUM*RES_W-1:0] result_q, result_d;

    logic [ISSUE_NUM-1:0]       pending;
    logic                       any_pending;
    logic [LANE_W-1:0]          sel;

    // Lowest pending lane wins; the MDU operand bus always carries that lane's fields.
    always_comb begin
        pending     = req & ~done_q;
        any_pending = |pending;
        sel         = '0;
        mdu_op      = op[OP_W-1:0];
        mdu_a       = src_a[DATA_W-1:0];
        mdu_b       = src_b[DATA_W-1:0];
        for (int i = ISSUE_NUM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel    = LANE_W'(i);
                mdu_op = op[i*OP_W +: OP_W];
                mdu_a  = src_a[i*DATA_W +: DATA_W];
                mdu_b  = src_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        done_d    = done_q;
        result_d  = result_q;
        mdu_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    done_d = '0;
                end else if (any_pending) begin
                    mdu_start = 1'b1;
                    lane_d    = sel;
                    state_d   = RUN;
                end else if (!stall_ex && (|req)) begin
                    done_d = '0;
                end
            end
            RUN: begin
                if (flush) begin
                    done_d  = '0;
                    state_d = mdu_done ? IDLE : DRAIN;
                end else if (mdu_done) begin
                    for (int i = 0; i < ISSUE_NUM; i++) begin
                        if (lane_q == LANE_W'(i)) begin
                            result_d[i*RES_W +: RES_W] = mdu_result;
                            done_d[i]                  = 1'b1;
                        end
                    end
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // The MDU cannot be aborted, so wait out the orphaned op and drop its result.
                if (mdu_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            mdu_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            done_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign stall_req    = any_pending | ((state_q == DRAIN) & (|req));
    assign result_valid = done_q;
    assign result       = result_q;

endmodule

// File: tb/tb_mdu_issue_scheduler.sv
// Directed bench for mdu_issue_scheduler: a behavioural MDU with programmable latency,
// a lane-level reference model checked every cycle, and literal expectations per scenario.
module tb_mdu_issue_scheduler;
    localparam int ISSUE_NUM = 2;
    localparam int OP_W      = 4;
    localparam int DATA_W    = 32;
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;

    logic         clk = 1'b0;
    logic         rst, flush, stall_ex;
    logic [1:0]   req;
    logic [7:0]   op;
    logic [63:0]  src_a, src_b;
    logic         mdu_start;
    logic [3:0]   mdu_op;
    logic [31:0]  mdu_a, mdu_b;
    logic         mdu_done;
    logic [63:0]  mdu_result;
    logic [127:0] result;
    logic [1:0]   result_valid;
    logic         stall_req;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 2;
    int mdu_cnt = 0;
    logic [63:0] mdu_calc = '0;
    int stall_cnt = 0;
    int start_log[$];
    logic [67:0] start_ops[$];
    bit chk_en = 1'b0;

    // Reference model: which lanes have finished, their results, and whether an MDU op is outstanding.
    logic [1:0]  m_fin   = '0;
    logic [63:0] m_res [2];
    logic        m_busy  = 1'b0;
    int          m_owner = -1;

    mdu_issue_scheduler #(.ISSUE_NUM(ISSUE_NUM), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex),
        .req(req), .op(op), .src_a(src_a), .src_b(src_b),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_done(mdu_done), .mdu_result(mdu_result),
        .result(result), .result_valid(result_valid), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qs, rs;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            OP_MULT:  return sa * sb;
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return '0;
                qs = $signed(a) / $signed(b);
                rs = $signed(a) % $signed(b);
                return {rs, qs};
            end
            OP_DIVU: begin
                if (b == 32'd0) return '0;
                return {a % b, a / b};
            end
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int q_at(input int idx);
        if (idx < start_log.size()) return start_log[idx];
        return -1;
    endfunction

    function automatic logic [67:0] ops_at(input int idx);
        if (idx < start_ops.size()) return start_ops[idx];
        return '1;
    endfunction

    // Advance to just after the next rising edge; the MDU model raises done L cycles after start.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mdu_done = 1'b0;
        if (mdu_cnt > 0) begin
            mdu_cnt--;
            if (mdu_cnt == 0) begin
                mdu_done   = 1'b1;
                mdu_result = mdu_calc;
            end
        end
    endtask

    task automatic peek();
        #2;
    endtask

    task automatic set_lane(input int i, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op[i*4 +: 4]     = o;
        src_a[i*32 +: 32] = a;
        src_b[i*32 +: 32] = b;
    endtask

    task automatic clear_logs();
        start_log.delete();
        start_ops.delete();
        stall_cnt = 0;
    endtask

    // Per-cycle compare against the model, MDU model arming, and model update.
    always @(negedge clk) begin
        logic [1:0] pend;
        int         first;
        logic       exp_stall, exp_start;
        pend  = req & ~m_fin;
        first = pend[0] ? 0 : 1;
        exp_stall = (|pend) || (m_busy && (m_owner < 0) && (|req));
        exp_start = !rst && !m_busy && (|pend) && !flush;
        if (chk_en) begin
            chk("stall_req", 64'(stall_req), 64'(exp_stall));
            chk("mdu_start", 64'(mdu_start), 64'(exp_start));
            chk("result_valid", 64'(result_valid), 64'(m_fin));
            if (exp_start && mdu_start) begin
                chk("mdu_op", 64'(mdu_op), 64'(op[first*4 +: 4]));
                chk("mdu_a", 64'(mdu_a), 64'(src_a[first*32 +: 32]));
                chk("mdu_b", 64'(mdu_b), 64'(src_b[first*32 +: 32]));
            end
            for (int i = 0; i < 2; i++) begin
                if (m_fin[i]) chk("result_lane", result[i*64 +: 64], m_res[i]);
            end
        end
        if (stall_req === 1'b1) stall_cnt++;
        if (mdu_start === 1'b1 && !rst) begin
            mdu_cnt  = lat;
            mdu_calc = calc(mdu_op, mdu_a, mdu_b);
            start_log.push_back(cyc);
            start_ops.push_back({mdu_op, mdu_a, mdu_b});
        end
        if (rst) begin
            m_fin   = '0;
            m_busy  = 1'b0;
            m_owner = -1;
        end else if (m_busy) begin
            if (mdu_done) begin
                if (flush) begin
                    m_fin = '0;
                end else if (m_owner >= 0) begin
                    m_fin[m_owner] = 1'b1;
                    m_res[m_owner] = calc(op[m_owner*4 +: 4], src_a[m_owner*32 +: 32], src_b[m_owner*32 +: 32]);
                end
                m_busy = 1'b0;
            end else if (flush) begin
                m_fin   = '0;
                m_owner = -1;
            end
        end else if (flush) begin
            m_fin = '0;
        end else if (|pend) begin
            m_busy  = 1'b1;
            m_owner = first;
        end else if ((|req) && !stall_ex) begin
            m_fin = '0;
        end
    end

    initial begin
        int t;
        rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; req = '0; op = '0;
        src_a = '0; src_b = '0; mdu_done = 1'b0; mdu_result = '0;
        m_res[0] = '0; m_res[1] = '0;

        // Reset state
        step();
        chk_en = 1'b1;
        step(); peek();
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_start", 64'(mdu_start), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_result0", result[63:0], 64'd0);
        rst = 1'b0;

        // Single lane MULT 3 * -1, L=3
        step(); lat = 3;
        set_lane(0, OP_MULT, 32'd3, 32'hFFFF_FFFF); req = 2'b01;
        clear_logs(); t = cyc;
        repeat (4) step(); peek();
        chk("s1_valid", 64'(result_valid), 64'h1);
        chk("s1_res0", result[63:0], 64'hFFFF_FFFF_FFFF_FFFD);
        chk("s1_stall_low", 64'(stall_req), 64'd0);
        chk("s1_stall_cycles", 64'(stall_cnt), 64'd4);
        step(); req = 2'b00; peek();
        chk("s1_retired", 64'(result_valid), 64'd0);
        chk("s1_starts", 64'(start_log.size()), 64'd1);
        chk("s1_start_cyc", 64'(q_at(0)), 64'(t));
        chk("s1_start_ops", 64'(ops_at(0) >> 4), 64'({OP_MULT, 32'd3, 32'hFFFF_FFFF} >> 4));
        chk("s1_start_opb", 64'(ops_at(0) & 68'hF), 64'hF);

        // Dual lane: DIVU 7/2 then MULTU 5*6, L=2
        step(); lat = 2;
        set_lane(0, OP_DIVU, 32'd7, 32'd2); set_lane(1, OP_MULTU, 32'd5, 32'd6); req = 2'b11;
        clear_logs(); t = cyc;
        repeat (6) step(); peek();
        chk("s2_valid", 64'(result_valid), 64'h3);
        chk("s2_res0", result[63:0], 64'h0000_0001_0000_0003);
        chk("s2_res1", result[127:64], 64'h0000_0000_0000_001E);
        chk("s2_stall_low", 64'(stall_req), 64'd0);
        chk("s2_stall_cycles", 64'(stall_cnt), 64'd6);
        chk("s2_start0", 64'(q_at(0)), 64'(t));
        chk("s2_start1", 64'(q_at(1)), 64'(t + 3));
        step(); req = 2'b00;

        // Flush while RUN, MDU latency 4: orphaned op drains before the new bundle starts
        step(); lat = 4;
        set_lane(0, OP_MULTU, 32'd9, 32'd9); req = 2'b01;
        clear_logs(); t = cyc;
        step(); flush = 1'b1;
        step(); flush = 1'b0; set_lane(0, OP_MULT, 32'hFFFF_FFFE, 32'd7); stall_cnt = 0;
        step(); step(); peek();
        chk("s3_no_result", 64'(result_valid), 64'd0);
        chk("s3_stall_held", 64'(stall_req), 64'd1);
        chk("s3_no_start", 64'(mdu_start), 64'd0);
        step(); peek();
        chk("s3_restart", 64'(mdu_start), 64'd1);
        chk("s3_valid_low", 64'(result_valid), 64'd0);
        step(); peek();
        chk("s3_stall_cycles", 64'(stall_cnt), 64'd4);
        repeat (4) step(); peek();
        chk("s3_valid", 64'(result_valid), 64'h1);
        chk("s3_res0", result[63:0], 64'hFFFF_FFFF_FFFF_FFF2);
        chk("s3_start0", 64'(q_at(0)), 64'(t));
        chk("s3_start1", 64'(q_at(1)), 64'(t + 5));
        step(); req = 2'b00;

        // Flush coincident with mdu_done
        step(); lat = 2;
        set_lane(0, OP_MULTU, 32'd4, 32'd4); req = 2'b01;
        clear_logs(); t = cyc;
        step(); step(); flush = 1'b1;
        step(); flush = 1'b0; set_lane(0, OP_MULTU, 32'd3, 32'd3); peek();
        chk("s4_valid_low", 64'(result_valid), 64'd0);
        chk("s4_restart", 64'(mdu_start), 64'd1);
        chk("s4_restart_a", 64'(mdu_a), 64'd3);
        repeat (3) step(); peek();
        chk("s4_valid", 64'(result_valid), 64'h1);
        chk("s4_res0", result[63:0], 64'd9);
        chk("s4_start1", 64'(q_at(1)), 64'(t + 3));
        step(); req = 2'b00;

        // Downstream stall holds the completed bundle for 5 cycles
        step(); lat = 2;
        set_lane(0, OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        set_lane(1, OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req = 2'b11; stall_ex = 1'b1;
        clear_logs(); t = cyc;
        repeat (6) step();
        for (int k = 0; k < 5; k++) begin
            peek();
            chk("s5_valid", 64'(result_valid), 64'h3);
            chk("s5_res0", result[63:0], 64'h0000_0001_0000_0000);
            chk("s5_res1", result[127:64], 64'd1);
            chk("s5_no_start", 64'(mdu_start), 64'd0);
            step();
        end
        stall_ex = 1'b0; peek();
        chk("s5_valid_at_release", 64'(result_valid), 64'h3);
        step(); req = 2'b00; peek();
        chk("s5_retired", 64'(result_valid), 64'd0);
        chk("s5_starts", 64'(start_log.size()), 64'd2);

        // Reset during RUN, then a stray late mdu_done
        step(); lat = 3;
        set_lane(0, OP_MULTU, 32'd2, 32'd3); req = 2'b01;
        clear_logs(); t = cyc;
        step(); rst = 1'b1; mdu_cnt = 0;
        step(); peek();
        chk("s6_start_low", 64'(mdu_start), 64'd0);
        chk("s6_valid_low", 64'(result_valid), 64'd0);
        chk("s6_stall_req", 64'(stall_req), 64'd1);
        step(); rst = 1'b0; req = 2'b00; mdu_done = 1'b1; mdu_result = 64'hDEAD_BEEF;
        step(); peek();
        chk("s6_late_done_ignored", 64'(result_valid), 64'd0);
        chk("s6_stall_low", 64'(stall_req), 64'd0);
        chk("s6_starts", 64'(start_log.size()), 64'd1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
